// File: rtl/lc3_mem_if.sv
// Core-side memory bus between the LC-3 control/datapath (MAR/MDR) and the memory controller.
interface lc3_mem_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdy;

    modport master (output req, we, addr, wdata, input rdata, rdy);
    modport slave  (input req, we, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO controller: SRAM below xFE00 with programmable wait states,
// keyboard/display/machine-control registers above, plus memRDY generation.
module lc3_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    lc3_mem_if.slave    bus,
    output logic        sram_ce,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    input  logic [7:0]  kb_data,
    input  logic        kb_valid,
    output logic [7:0]  dd_data,
    output logic        dd_valid,
    input  logic        dd_ready,
    output logic        kb_int,
    output logic        dd_int,
    output logic        run
);
    localparam int unsigned CNT_W  = 4;
    localparam logic [15:0] IO_BASE   = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    typedef enum logic [1:0] {IDLE, ACCESS, IO, RESP} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               we_q;
    logic [15:0]        addr_q, wdata_q, rdata_q;
    logic               kb_rdy, kb_ie, dd_ie, run_q, dd_valid_q;
    logic [7:0]         kbdr, dd_data_q;
    logic [15:0]        io_rdata;
    logic               io_wr, kbdr_rd;
    logic               is_kbsr, is_kbdr, is_dsr, is_ddr, is_mcr;

    // State register; async reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req) state_nx = (bus.addr < IO_BASE) ? ACCESS : IO;
            ACCESS:  if (cnt == '0) state_nx = RESP;
            IO:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch and wait-state counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
        end else if (state == IDLE && bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt     <= CNT_W'(WAIT_CYCLES);
        end else if (state == ACCESS && cnt != '0) begin
            cnt     <= cnt - CNT_W'(1);
        end
    end

    assign is_kbsr = (addr_q == KBSR_ADDR);
    assign is_kbdr = (addr_q == KBDR_ADDR);
    assign is_dsr  = (addr_q == DSR_ADDR);
    assign is_ddr  = (addr_q == DDR_ADDR);
    assign is_mcr  = (addr_q == MCR_ADDR);
    assign io_wr   = (state == IO) && we_q;
    assign kbdr_rd = (state == IO) && !we_q && is_kbdr;

    // Device register read mux; unmapped IO and DDR read as zero.
    always_comb begin
        io_rdata = '0;
        if (is_kbsr)      io_rdata = {kb_rdy, kb_ie, 14'd0};
        else if (is_kbdr) io_rdata = {8'h00, kbdr};
        else if (is_dsr)  io_rdata = {!dd_valid_q, dd_ie, 14'd0};
        else if (is_mcr)  io_rdata = {run_q, 15'd0};
    end

    // Read data holds across writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state == ACCESS && cnt == '0 && !we_q) begin
            rdata_q <= sram_rdata;
        end else if (state == IO && !we_q) begin
            rdata_q <= io_rdata;
        end
    end

    // Keyboard: a new strobe wins over a same-edge KBDR read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kb_rdy <= 1'b0;
            kbdr   <= '0;
            kb_ie  <= 1'b0;
        end else begin
            if (kb_valid) begin
                kbdr   <= kb_data;
                kb_rdy <= 1'b1;
            end else if (kbdr_rd) begin
                kb_rdy <= 1'b0;
            end
            if (io_wr && is_kbsr) kb_ie <= wdata_q[14];
        end
    end

    // Display and machine control; DDR writes while busy are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dd_valid_q <= 1'b0;
            dd_data_q  <= '0;
            dd_ie      <= 1'b0;
            run_q      <= 1'b1;
        end else begin
            if (io_wr && is_ddr && !dd_valid_q) begin
                dd_data_q  <= wdata_q[7:0];
                dd_valid_q <= 1'b1;
            end else if (dd_valid_q && dd_ready) begin
                dd_valid_q <= 1'b0;
            end
            if (io_wr && is_dsr) dd_ie <= wdata_q[14];
            if (io_wr && is_mcr) run_q <= wdata_q[15];
        end
    end

    assign bus.rdy    = (state == RESP);
    assign bus.rdata  = rdata_q;
    assign sram_ce    = (state == ACCESS);
    assign sram_we    = (state == ACCESS) && we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign dd_data    = dd_data_q;
    assign dd_valid   = dd_valid_q;
    assign kb_int     = kb_rdy && kb_ie;
    assign dd_int     = !dd_valid_q && dd_ie;
    assign run        = run_q;
endmodule
